// File: rtl/alu_frame_ctrl_if.sv
`default_nettype none
//============================================================================
// Module   : alu_frame_ctrl_if
// Brief    : RX stream, ALU operand/result, TX stream and status bundle.
// Revision : 1.0 - initial release
//============================================================================
interface alu_frame_ctrl_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_valid;
    logic               o_rx_ready;

    logic [NB_DATA-1:0] o_alu_a;
    logic [NB_DATA-1:0] o_alu_b;
    logic [NB_OP-1:0]   o_alu_op;
    logic [NB_DATA-1:0] i_alu_result;
    logic               i_alu_zero;
    logic               i_alu_overflow;

    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_valid;
    logic               i_tx_ready;

    logic               o_busy;
    logic               o_timeout;

    // The controller is the slave side; the surrounding top level is master.
    modport slave (
        input  i_rx_data, i_rx_valid, i_alu_result, i_alu_zero,
               i_alu_overflow, i_tx_ready,
        output o_rx_ready, o_alu_a, o_alu_b, o_alu_op, o_tx_data,
               o_tx_valid, o_busy, o_timeout
    );

    modport master (
        output i_rx_data, i_rx_valid, i_alu_result, i_alu_zero,
               i_alu_overflow, i_tx_ready,
        input  o_rx_ready, o_alu_a, o_alu_b, o_alu_op, o_tx_data,
               o_tx_valid, o_busy, o_timeout
    );
endinterface
`default_nettype wire

// File: rtl/alu_frame_ctrl.sv
`default_nettype none
//============================================================================
// Module   : alu_frame_ctrl
// Brief    : Collects A,B,OP bytes, runs one ALU op, returns RESULT,FLAGS.
// Revision : 1.0 - initial release
//============================================================================
module alu_frame_ctrl #(
    parameter int NB_DATA     = 8,
    parameter int NB_OP       = 6,
    parameter int TIMEOUT_CYC = 1000000
) (
    input wire              i_clk,
    input wire              i_rst,
    alu_frame_ctrl_if.slave bus
);
    localparam int NB_CNT = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [NB_CNT-1:0] c_cnt_max = NB_CNT'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_GET_A    = 3'd0,
        ST_GET_B    = 3'd1,
        ST_GET_OP   = 3'd2,
        ST_EXEC     = 3'd3,
        ST_SEND_RES = 3'd4,
        ST_SEND_FLG = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [NB_CNT-1:0]  r_cnt;
    logic [NB_DATA-1:0] r_alu_a;
    logic [NB_DATA-1:0] r_alu_b;
    logic [NB_OP-1:0]   r_alu_op;
    logic [NB_DATA-1:0] r_res;
    logic [NB_DATA-1:0] r_flg;
    logic [NB_DATA-1:0] r_tx_data;
    logic               r_tx_valid;
    logic               r_timeout;

    logic               w_rx_ready;
    logic               w_accept;
    logic               w_in_wait;
    logic               w_expire;
    logic               w_inv;
    logic               w_tx_fire;
    logic [NB_DATA-1:0] w_flg;

    assign w_rx_ready = (r_state == ST_GET_A) || (r_state == ST_GET_B) ||
                        (r_state == ST_GET_OP);
    assign w_accept   = bus.i_rx_valid && w_rx_ready;
    assign w_in_wait  = (r_state == ST_GET_B) || (r_state == ST_GET_OP);
    // A byte landing on the expiring cycle takes priority over the abort.
    assign w_expire   = w_in_wait && !w_accept && (r_cnt == c_cnt_max);
    assign w_tx_fire  = r_tx_valid && bus.i_tx_ready;

    always_comb begin
        w_inv = 1'b1;
        case (r_alu_op)
            NB_OP'(6'b100000), NB_OP'(6'b100010), NB_OP'(6'b100100),
            NB_OP'(6'b100101), NB_OP'(6'b100110), NB_OP'(6'b100111),
            NB_OP'(6'b000011), NB_OP'(6'b000010): w_inv = 1'b0;
            default:                              w_inv = 1'b1;
        endcase
    end

    assign w_flg = NB_DATA'({w_inv, bus.i_alu_overflow, bus.i_alu_zero});

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_GET_A;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_GET_A:    if (w_accept) w_state_next = ST_GET_B;
            ST_GET_B:    if (w_accept) w_state_next = ST_GET_OP;
                         else if (w_expire) w_state_next = ST_GET_A;
            ST_GET_OP:   if (w_accept) w_state_next = ST_EXEC;
                         else if (w_expire) w_state_next = ST_GET_A;
            ST_EXEC:     w_state_next = ST_SEND_RES;
            ST_SEND_RES: if (w_tx_fire) w_state_next = ST_SEND_FLG;
            ST_SEND_FLG: if (w_tx_fire) w_state_next = ST_GET_A;
            default:     w_state_next = ST_GET_A;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt      <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_res      <= '0;
            r_flg      <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_expire;

            if (w_in_wait && !w_accept && !w_expire) r_cnt <= r_cnt + NB_CNT'(1);
            else                                     r_cnt <= '0;

            if (w_expire) begin
                r_alu_a  <= '0;
                r_alu_b  <= '0;
                r_alu_op <= '0;
            end else if (w_accept) begin
                case (r_state)
                    ST_GET_A:  r_alu_a  <= bus.i_rx_data;
                    ST_GET_B:  r_alu_b  <= bus.i_rx_data;
                    ST_GET_OP: r_alu_op <= bus.i_rx_data[NB_OP-1:0];
                    default:   ;
                endcase
            end

            if (r_state == ST_EXEC) begin
                r_res <= bus.i_alu_result;
                r_flg <= w_flg;
            end

            // RESULT is presented one cycle into SEND_RES, then held until taken.
            if (r_state == ST_SEND_RES) begin
                if (!r_tx_valid) begin
                    r_tx_data  <= r_res;
                    r_tx_valid <= 1'b1;
                end else if (bus.i_tx_ready) begin
                    r_tx_data  <= r_flg;
                end
            end else if (r_state == ST_SEND_FLG && bus.i_tx_ready) begin
                r_tx_valid <= 1'b0;
            end
        end
    end

    assign bus.o_rx_ready = w_rx_ready;
    assign bus.o_alu_a    = r_alu_a;
    assign bus.o_alu_b    = r_alu_b;
    assign bus.o_alu_op   = r_alu_op;
    assign bus.o_tx_data  = r_tx_data;
    assign bus.o_tx_valid = r_tx_valid;
    assign bus.o_busy     = (r_state == ST_EXEC) || (r_state == ST_SEND_RES) ||
                            (r_state == ST_SEND_FLG);
    assign bus.o_timeout  = r_timeout;
endmodule
`default_nettype wire

// File: tb/tb_alu_frame_ctrl.sv
`default_nettype none
//============================================================================
// Module   : tb_alu_frame_ctrl
// Brief    : Directed frames against alu_frame_ctrl with a behavioural ALU.
// Revision : 1.0 - initial release
//============================================================================
module tb_alu_frame_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_to  = 0;

    alu_frame_ctrl_if #(.NB_DATA(8), .NB_OP(6)) bus ();

    alu_frame_ctrl #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_CYC(16)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: shifts move A by one position.
    logic [8:0] w_alu;
    always_comb begin
        w_alu = 9'd0;
        case (bus.o_alu_op)
            6'h20:   w_alu = {1'b0, bus.o_alu_a} + {1'b0, bus.o_alu_b};
            6'h22:   w_alu = {1'b0, bus.o_alu_a} - {1'b0, bus.o_alu_b};
            6'h24:   w_alu = {1'b0, bus.o_alu_a & bus.o_alu_b};
            6'h25:   w_alu = {1'b0, bus.o_alu_a | bus.o_alu_b};
            6'h26:   w_alu = {1'b0, bus.o_alu_a ^ bus.o_alu_b};
            6'h27:   w_alu = {1'b0, ~(bus.o_alu_a | bus.o_alu_b)};
            6'h03:   w_alu = {1'b0, bus.o_alu_a[7], bus.o_alu_a[7:1]};
            6'h02:   w_alu = {2'b00, bus.o_alu_a[7:1]};
            default: w_alu = 9'd0;
        endcase
        bus.i_alu_result   = w_alu[7:0];
        bus.i_alu_zero     = (w_alu[7:0] == 8'd0);
        bus.i_alu_overflow = w_alu[8];
    end

    always @(negedge clk) if (bus.o_timeout) n_to++;

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] a,
                             input logic [7:0] b, input logic [7:0] op,
                             input int idle, input logic [7:0] res,
                             input logic [7:0] flg);
        check_value({tag, "_rdy_a"}, 32'(bus.o_rx_ready), 32'd1);
        send_byte(a);
        send_byte(b);
        repeat (idle) @(negedge clk);
        send_byte(op);
        check_value({tag, "_busy_exec"}, 32'(bus.o_busy), 32'd1);
        check_value({tag, "_rdy_exec"}, 32'(bus.o_rx_ready), 32'd0);
        check_value({tag, "_vld_exec"}, 32'(bus.o_tx_valid), 32'd0);
        @(negedge clk);
        check_value({tag, "_vld_n1"}, 32'(bus.o_tx_valid), 32'd0);
        @(negedge clk);
        check_value({tag, "_vld_res"}, 32'(bus.o_tx_valid), 32'd1);
        check_value({tag, "_res"}, 32'(bus.o_tx_data), 32'(res));
        @(negedge clk);
        check_value({tag, "_vld_flg"}, 32'(bus.o_tx_valid), 32'd1);
        check_value({tag, "_flg"}, 32'(bus.o_tx_data), 32'(flg));
        @(negedge clk);
        check_value({tag, "_vld_end"}, 32'(bus.o_tx_valid), 32'd0);
        check_value({tag, "_busy_end"}, 32'(bus.o_busy), 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.i_rx_data  = 8'h00;
        bus.i_rx_valid = 1'b0;
        bus.i_tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_value("rst_tx_valid", 32'(bus.o_tx_valid), 32'd0);
        check_value("rst_tx_data", 32'(bus.o_tx_data), 32'd0);
        check_value("rst_busy", 32'(bus.o_busy), 32'd0);
        check_value("rst_timeout", 32'(bus.o_timeout), 32'd0);
        check_value("rst_alu_a", 32'(bus.o_alu_a), 32'd0);
        check_value("rst_alu_op", 32'(bus.o_alu_op), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_value("rst_rx_ready", 32'(bus.o_rx_ready), 32'd1);

        // Idle in GET_A must never time out.
        repeat (20) @(negedge clk);
        check_value("idle_a_no_to", 32'(n_to), 32'd0);

        run_frame("add", 8'h05, 8'h03, 8'h20, 0, 8'h08, 8'h00);
        run_frame("add_cz", 8'hFF, 8'h01, 8'h20, 0, 8'h00, 8'h03);
        run_frame("sub", 8'h03, 8'h05, 8'h22, 0, 8'hFE, 8'h02);
        run_frame("sra", 8'h81, 8'h00, 8'h03, 0, 8'hC0, 8'h00);
        run_frame("inv", 8'h12, 8'h34, 8'h3F, 0, 8'h00, 8'h05);
        run_frame("opmask", 8'h0F, 8'h0F, 8'hE4, 0, 8'h0F, 8'h00);
        check_value("opmask_op", 32'(bus.o_alu_op), 32'h24);

        // Backpressure on RESULT.
        bus.i_tx_ready = 1'b0;
        send_byte(8'h0A);
        send_byte(8'h05);
        send_byte(8'h26);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check_value("bp_data", 32'(bus.o_tx_data), 32'h0F);
            check_value("bp_valid", 32'(bus.o_tx_valid), 32'd1);
            check_value("bp_rx_ready", 32'(bus.o_rx_ready), 32'd0);
            @(negedge clk);
        end
        bus.i_tx_ready = 1'b1;
        @(negedge clk);
        check_value("bp_flg", 32'(bus.o_tx_data), 32'h00);
        check_value("bp_flg_vld", 32'(bus.o_tx_valid), 32'd1);
        @(negedge clk);
        check_value("bp_end_vld", 32'(bus.o_tx_valid), 32'd0);

        // Timeout after 16 idle cycles between B and OP.
        send_byte(8'h12);
        send_byte(8'h34);
        repeat (15) @(negedge clk);
        check_value("to_not_yet", 32'(n_to), 32'd0);
        check_value("to_hold_a", 32'(bus.o_alu_a), 32'h12);
        @(negedge clk);
        check_value("to_pulse", 32'(bus.o_timeout), 32'd1);
        check_value("to_clr_a", 32'(bus.o_alu_a), 32'd0);
        check_value("to_clr_b", 32'(bus.o_alu_b), 32'd0);
        check_value("to_rx_ready", 32'(bus.o_rx_ready), 32'd1);
        @(negedge clk);
        check_value("to_pulse_end", 32'(bus.o_timeout), 32'd0);
        check_value("to_count", 32'(n_to), 32'd1);

        // OP arriving on the expiring cycle wins over the abort.
        run_frame("or_edge", 8'h0F, 8'hF0, 8'h25, 15, 8'hFF, 8'h00);
        check_value("edge_no_to", 32'(n_to), 32'd1);

        // Reset while FLAGS is on the wire.
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h20);
        repeat (3) @(negedge clk);
        check_value("rs_in_flg", 32'(bus.o_tx_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_value("rs_vld", 32'(bus.o_tx_valid), 32'd0);
        check_value("rs_data", 32'(bus.o_tx_data), 32'd0);
        check_value("rs_alu_a", 32'(bus.o_alu_a), 32'd0);
        check_value("rs_busy", 32'(bus.o_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_frame("post_rst", 8'h02, 8'h02, 8'h22, 0, 8'h00, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
